// File: rtl/wb_serializer_fifo_if.sv
// Wishbone slave bus bundle for wb_serializer_fifo: request, address/data and
// the registered ACK/ERR/read-data response.
// Ports: CYC_I, STB_I, WE_I, ADR_I[31:0], DAT_I[31:0] toward the slave;
//        DAT_O[31:0], ACK_O, ERR_O back toward the master.
interface wb_serializer_fifo_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        ERR_O;

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    output DAT_O, ACK_O, ERR_O
  );

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O, ERR_O
  );
endinterface

// File: rtl/wb_serializer_fifo.sv
// Wishbone-fed TX FIFO plus MSB-first bit serializer with programmable bit period.
// Latency: bus ACK/ERR one clock after request; first data bit 2 clocks after the TXDATA ack cycle from idle.
// Backpressure: TXDATA write into a full FIFO returns ERR_O, drops the word and sets sticky overflow.
// Ports: clk_i, rst_ni (sync, active-low); wb (slave modport: CYC/STB/WE/ADR/DAT in, DAT/ACK/ERR out);
//        data_o serial data, ena_o bit-valid, eot_o end-of-word pulse, irq_o idle-and-empty interrupt.
// Option: define SER_PARITY_EN to append an even-parity bit to every word (STATUS[4] reads 1).
module wb_serializer_fifo #(
  parameter int WORD_W     = 27,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wb_serializer_fifo_if.slave   wb,
  output logic                  data_o,
  output logic                  ena_o,
  output logic                  eot_o,
  output logic                  irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);
`ifdef SER_PARITY_EN
  localparam logic PAR_PRESENT = 1'b1;
`else
  localparam logic PAR_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PAR,
    S_EOT
  } state_t;

  state_t state_q, state_d;

  // Control register
  logic [DIV_W-1:0] div_q;
  logic             ie_q;
  logic             en_q;
  logic             ovf_q;

  // FIFO
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;
  logic              empty, full, push, pop;

  // Serializer datapath
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic [DIV_W-1:0]  divcnt;
`ifdef SER_PARITY_EN
  logic              par_q;
`endif

  // Bus
  logic        req, req_q, fire;
  logic        ack_d, err_d, ack_q, err_q;
  logic        wr_ctrl, set_ovf, clr_ovf;
  logic [31:0] rdata, dat_q, ctrl_rd, status_rd;
  logic        unused_bits;

  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = (state_q == S_LOAD);

  // One response per rising edge of the request, even if STB_I is held.
  assign req  = wb.CYC_I & wb.STB_I;
  assign fire = req & ~req_q;

  assign unused_bits = ^{wb.ADR_I[31:4], wb.ADR_I[1:0], wb.DAT_I};

  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[DIV_W+1:0]     = {div_q, ie_q, en_q};
    status_rd              = '0;
    status_rd[15:8]        = 8'(level);
    status_rd[4]           = PAR_PRESENT;
    status_rd[3]           = (state_q != S_IDLE);
    status_rd[2]           = ovf_q;
    status_rd[1]           = full;
    status_rd[0]           = empty;
  end

  // Address decode; all side effects commit on the edge that raises ACK/ERR.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    push    = 1'b0;
    wr_ctrl = 1'b0;
    set_ovf = 1'b0;
    clr_ovf = 1'b0;
    rdata   = '0;
    if (fire) begin
      unique case (wb.ADR_I[3:2])
        2'd0: begin
          if (wb.WE_I) begin
            // A pop on the same edge frees a slot, so a full FIFO can still accept.
            if (!full || pop) begin
              push  = 1'b1;
              ack_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              set_ovf = 1'b1;
            end
          end else begin
            ack_d = 1'b1;
          end
        end
        2'd1: begin
          ack_d   = 1'b1;
          wr_ctrl = wb.WE_I;
          rdata   = ctrl_rd;
        end
        2'd2: begin
          ack_d   = 1'b1;
          clr_ovf = wb.WE_I & wb.DAT_I[2];
          rdata   = status_rd;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      div_q <= DIV_INIT;
      ie_q  <= 1'b0;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      req_q <= req;
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= ack_d ? rdata : '0;
      if (wr_ctrl) begin
        div_q <= wb.DAT_I[DIV_W+1:2];
        ie_q  <= wb.DAT_I[1];
        en_q  <= wb.DAT_I[0];
      end
      if (set_ovf) ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign wb.ACK_O = ack_q;
  assign wb.ERR_O = err_q;
  assign wb.DAT_O = dat_q;

  // FIFO storage carries no reset; pointers and level define its contents.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wb.DAT_I[WORD_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en_q && !empty) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (divcnt == '0 && bitcnt == '0) begin
`ifdef SER_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_EOT;
`endif
        end
      end
      S_PAR:   if (divcnt == '0) state_d = S_EOT;
      S_EOT:   state_d = (en_q && !empty) ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    data_o = 1'b0;
    ena_o  = 1'b0;
    eot_o  = 1'b0;
    irq_o  = ie_q & empty & (state_q == S_IDLE);
    unique case (state_q)
      S_SHIFT: begin
        data_o = shreg[WORD_W-1];
        ena_o  = 1'b1;
      end
`ifdef SER_PARITY_EN
      S_PAR: begin
        data_o = par_q;
        ena_o  = 1'b1;
      end
`endif
      S_EOT:   eot_o = 1'b1;
      default: ;
    endcase
  end

  // Shift datapath; the divider is re-read at every reload so a DIV write lands on the next bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
`ifdef SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_LOAD: begin
          shreg  <= mem[rptr];
          bitcnt <= BW'(WORD_W - 1);
          divcnt <= div_q;
`ifdef SER_PARITY_EN
          par_q  <= ^mem[rptr];
`endif
        end
        S_SHIFT: begin
          if (divcnt == '0) begin
            shreg  <= shreg << 1;
            divcnt <= div_q;
            if (bitcnt != '0) bitcnt <= bitcnt - BW'(1);
          end else begin
            divcnt <= divcnt - DIV_W'(1);
          end
        end
        S_PAR: begin
          if (divcnt == '0) divcnt <= div_q;
          else              divcnt <= divcnt - DIV_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serializer_fifo.sv
// Directed bench for wb_serializer_fifo: register access, serial framing,
// bit-period divider, FIFO full/overflow, interrupt and mid-word reset.
module tb_wb_serializer_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic data, ena, eot, irq;

  wb_serializer_fifo_if bus();

  wb_serializer_fifo dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb     (bus),
    .data_o (data),
    .ena_o  (ena),
    .eot_o  (eot),
    .irq_o  (irq)
  );

`ifdef SER_PARITY_EN
  localparam int          PBITS = 1;
  localparam logic [31:0] PB    = 32'h10;
`else
  localparam int          PBITS = 0;
  localparam logic [31:0] PB    = 32'h0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]  rd;
  logic         ack, err;
  logic [127:0] s;
  int           n, lat;
  logic         eot_ok;
  logic         seen;

  logic [26:0] words [8] = '{27'h0000001, 27'h7FFFFFF, 27'h1234567, 27'h2AAAAAA,
                             27'h5555555, 27'h0F0F0F0, 27'h4000000, 27'h3C3C3C3};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    output logic [31:0] rdat, output logic a, output logic e);
    @(negedge clk);
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = we;
    bus.ADR_I = adr;  bus.DAT_I = dat;
    @(negedge clk);
    a = bus.ACK_O; e = bus.ERR_O; rdat = bus.DAT_O;
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
  endtask

  // Per-cycle serial stream; lat = negedge index of the first ena cycle.
  task automatic capture(output logic [127:0] st, output int cnt, output int first, output logic eo);
    st = '0; cnt = 0; first = 0; eo = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (ena) begin
        if (cnt == 0) first = c;
        st = {st[126:0], data};
        cnt++;
      end else if (cnt > 0) begin
        eo = eot;
        break;
      end
    end
  endtask

  function automatic logic [127:0] expand(input logic [26:0] w, input int div);
    logic [127:0] r = '0;
    for (int i = 26; i >= 0; i--)
      for (int d = 0; d <= div; d++) r = {r[126:0], w[i]};
`ifdef SER_PARITY_EN
    for (int d = 0; d <= div; d++) r = {r[126:0], ^w};
`endif
    return r;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
    bus.ADR_I = '0;   bus.DAT_I = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {data, ena, eot, irq, bus.ACK_O, bus.ERR_O}, 0);
    check("rst_dat_o", bus.DAT_O, 0);
    rst_n = 1'b1;

    wb(1'b0, 32'h8, 0, rd, ack, err);
    check("status_after_rst", rd, 32'h1 | PB);
    check("status_ack", {ack, err}, 2'b10);
    wb(1'b0, 32'h4, 0, rd, ack, err);
    check("ctrl_after_rst", rd, 0);

    // DIV=0, EN=1: one clock per bit
    wb(1'b1, 32'h4, 32'h1, rd, ack, err);
    check("ctrl_wr_ack", {ack, err}, 2'b10);
    wb(1'b1, 32'h0, 32'h5A5A5A5, rd, ack, err);
    check("tx_wr_ack", {ack, err}, 2'b10);
    capture(s, n, lat, eot_ok);
    check("w1_latency", lat, 2);
    check("w1_bits", n, 27 + PBITS);
    check("w1_stream", s, expand(27'h5A5A5A5, 0));
    check("w1_eot", eot_ok, 1);
    @(negedge clk);
    check("w1_eot_single", {ena, eot}, 0);

    // DIV=3: four clocks per bit
    wb(1'b1, 32'h4, 32'hD, rd, ack, err);
    wb(1'b0, 32'h4, 0, rd, ack, err);
    check("ctrl_readback", rd, 32'hD);
    wb(1'b1, 32'h0, 32'h4000001, rd, ack, err);
    capture(s, n, lat, eot_ok);
    check("w2_ena_cycles", n, 108 + 4 * PBITS);
    check("w2_stream", s, expand(27'h4000001, 3));
    check("w2_eot", eot_ok, 1);

    // Fill FIFO with serializer disabled, overflow, then drain with IE set
    wb(1'b1, 32'h4, 32'h0, rd, ack, err);
    for (int k = 0; k < 8; k++) begin
      wb(1'b1, 32'h0, {5'b0, words[k]}, rd, ack, err);
      check("fill_ack", {ack, err}, 2'b10);
    end
    wb(1'b0, 32'h8, 0, rd, ack, err);
    check("status_full", rd, 32'h0802 | PB);
    wb(1'b1, 32'h0, 32'h1111111, rd, ack, err);
    check("overflow_err", {ack, err}, 2'b01);
    wb(1'b0, 32'h8, 0, rd, ack, err);
    check("status_ovf", rd, 32'h0806 | PB);
    wb(1'b1, 32'h8, 32'h4, rd, ack, err);
    check("ovf_clr_ack", {ack, err}, 2'b10);
    wb(1'b0, 32'h8, 0, rd, ack, err);
    check("status_ovf_clr", rd, 32'h0802 | PB);
    wb(1'b0, 32'hC, 0, rd, ack, err);
    check("adr3_err", {ack, err}, 2'b01);

    wb(1'b1, 32'h4, 32'h3, rd, ack, err);
    for (int k = 0; k < 8; k++) begin
      capture(s, n, lat, eot_ok);
      check("drain_gap", lat, 2);
      check("drain_bits", n, 27 + PBITS);
      check("drain_stream", s, expand(words[k], 0));
      check("drain_eot", eot_ok, 1);
    end
    check("irq_at_eot", irq, 0);
    @(negedge clk);
    check("irq_after_eot", irq, 1);
    wb(1'b0, 32'h8, 0, rd, ack, err);
    check("status_drained", rd, 32'h1 | PB);
    wb(1'b1, 32'h4, 32'h1, rd, ack, err);
    check("irq_ie_clear", irq, 0);

`ifdef SER_PARITY_EN
    wb(1'b1, 32'h0, 32'h7, rd, ack, err);
    capture(s, n, lat, eot_ok);
    check("par7_bits", n, 28);
    check("par7_last", s[0], 1);
    wb(1'b1, 32'h0, 32'h3, rd, ack, err);
    capture(s, n, lat, eot_ok);
    check("par3_bits", n, 28);
    check("par3_last", s[0], 0);
`endif

    // Reset in the middle of a word
    wb(1'b1, 32'h0, 32'h7FFFFFF, rd, ack, err);
    repeat (10) @(negedge clk);
    check("midword_active", ena, 1);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_outs", {data, ena, eot, irq, bus.ACK_O, bus.ERR_O}, 0);
      check("midrst_dat_o", bus.DAT_O, 0);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      seen = seen | ena | eot;
    end
    check("post_rst_quiet", seen, 0);
    wb(1'b0, 32'h8, 0, rd, ack, err);
    check("post_rst_status", rd, 32'h1 | PB);
    wb(1'b0, 32'h4, 0, rd, ack, err);
    check("post_rst_ctrl", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
